// File: rtl/acc_sched_pkg.sv
// -----------------------------------------------------------------------------
// acc_sched_pkg
//   Shared MMU accumulator-scheduler definitions:
//     - FSM state encodings (localparam constants used by the RTL) and a
//       matching enum type used for the debug state view
//     - ctrl_t: the per-column control bundle {wren, rden, sel, valid}
//     - mk_ctrl: helper that assembles a ctrl_t from its four fields
// -----------------------------------------------------------------------------
package acc_sched_pkg;

  // State encodings held in the controller's state register.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Same encodings as a named type, used for the exported debug state.
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_ACCUM = 2'd1,
    ACC_DRAIN = 2'd2,
    ACC_FLUSH = 2'd3
  } acc_state_e;

  // One column's worth of accumulator control for one cycle.
  //   wren  : push (psum + feedback) into the column FIFO
  //   rden  : pop the FIFO head at the clock edge
  //   sel   : feedback mux, 0 = zero, 1 = FIFO head
  //   valid : FIFO head is a finished sum presented downstream
  typedef struct packed {
    logic wren;
    logic rden;
    logic sel;
    logic valid;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(input logic wren, input logic rden,
                                    input logic sel, input logic valid);
    ctrl_t c;
    c.wren  = wren;
    c.rden  = rden;
    c.sel   = sel;
    c.valid = valid;
    return c;
  endfunction

endpackage

// File: rtl/acc_skew_chain.sv
// -----------------------------------------------------------------------------
// acc_skew_chain
//   Shift register of ctrl_t bundles that reproduces the systolic array's
//   diagonal column skew. Tap s carries the column-0 bundle delayed s+1
//   cycles, so tap s drives accumulator column s+1.
//
// Ports
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset, clears every stage
//   i_ctrl   : column-0 bundle for the current cycle
//   o_taps   : registered stages, o_taps[s] = i_ctrl delayed s+1 cycles
// -----------------------------------------------------------------------------
module acc_skew_chain
  import acc_sched_pkg::*;
#(
  parameter int STAGES = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  ctrl_t               i_ctrl,
  output ctrl_t [STAGES-1:0]  o_taps
);

  ctrl_t [STAGES-1:0] r_stage;

  // A stalled column-0 cycle enters as an all-zero bundle, so stalls
  // ripple down the columns exactly like real beats do.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_ctrl;
      for (int s = 1; s < STAGES; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_taps = r_stage;

endmodule

// File: rtl/acc_sched.sv
// -----------------------------------------------------------------------------
// acc_sched
//   Sequencing controller for the MMU accumulator bank. Walks K partial-sum
//   tiles of PE_SIZE rows into the per-column accumulator FIFOs, then drains
//   the finished sums, with every control line skewed one cycle per column.
//
// Ports
//   clk           : clock
//   rst_n         : asynchronous active-low reset (also the FIFO pointer reset)
//   start_i       : begin a job; ignored while busy_o=1
//   num_ktile_i   : K-tile count, sampled on an accepted start; 0 means 1
//   psum_valid_i  : column-0 psum row valid from the array (may gap)
//   out_ready_i   : downstream accepts a drained row (column-0 timing)
//   wren_o        : per-column FIFO write enable
//   rden_o        : per-column FIFO read enable (pop at edge, FWFT head)
//   sel_o         : per-column feedback select (0 = zero, 1 = FIFO head)
//   out_valid_o   : per-column drained-sum valid
//   tile_idx_o    : current tile index (column-0 view)
//   busy_o        : job in progress (any state other than IDLE)
//   done_o        : one-cycle pulse as the controller returns to IDLE
//   dbg_state_o   : FSM state, debug view
//
// Handshake: psum_valid_i and out_ready_i are per-cycle strobes. A cycle with
// the strobe high in the matching state is exactly one beat; a cycle with it
// low is a stall that holds all counters and emits an all-zero control
// bundle. There is no back-pressure toward the array: a psum row offered in
// ACCUM is always consumed.
// -----------------------------------------------------------------------------
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int PE_SIZE    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int KT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [KT_W-1:0]    num_ktile_i,
  input  logic               psum_valid_i,
  input  logic               out_ready_i,
  output logic [PE_SIZE-1:0] wren_o,
  output logic [PE_SIZE-1:0] rden_o,
  output logic [PE_SIZE-1:0] sel_o,
  output logic [PE_SIZE-1:0] out_valid_o,
  output logic [KT_W-1:0]    tile_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output acc_state_e         dbg_state_o
);

  // Row/beat counter also doubles as the flush-cycle counter.
  localparam int ROW_W = $clog2(PE_SIZE);

  // Each tile pushes PE_SIZE words per column before anything is popped
  // again, so a shallower FIFO would overflow on the first tile.
  if (FIFO_DEPTH < PE_SIZE) begin : g_bad_depth
    $error("acc_sched: FIFO_DEPTH (%0d) must be >= PE_SIZE (%0d)", FIFO_DEPTH, PE_SIZE);
  end
  // The skew chain needs at least one stage and FLUSH at least one cycle.
  if (PE_SIZE < 2) begin : g_bad_pe
    $error("acc_sched: PE_SIZE (%0d) must be >= 2", PE_SIZE);
  end

  logic [1:0]       r_state;
  logic [KT_W-1:0]  r_k;
  logic [KT_W-1:0]  r_tile;
  logic [ROW_W-1:0] r_row;
  logic             r_done;

  logic [KT_W-1:0]  w_k_req;
  logic             w_row_last;
  logic             w_tile_last;
  logic             w_flush_last;
  ctrl_t            w_c0;
  ctrl_t [PE_SIZE-2:0] w_taps;
  ctrl_t [PE_SIZE-1:0] w_col;

  // A K of zero would never leave ACCUM; run it as a single tile.
  assign w_k_req      = (num_ktile_i == '0) ? KT_W'(1) : num_ktile_i;
  assign w_row_last   = (r_row == ROW_W'(PE_SIZE - 1));
  assign w_flush_last = (r_row == ROW_W'(PE_SIZE - 2));
  assign w_tile_last  = (r_tile == (r_k - KT_W'(1)));

  // ---------------------------------------------------------------------------
  // Control FSM
  //   IDLE  -> ACCUM on start_i
  //   ACCUM -> DRAIN after the last row of tile K-1
  //   DRAIN -> FLUSH after PE_SIZE drain beats
  //   FLUSH -> IDLE after PE_SIZE-1 cycles, raising done for one cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_tile  <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_k     <= w_k_req;
            r_tile  <= '0;
            r_row   <= '0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (psum_valid_i) begin
            if (w_row_last) begin
              r_row <= '0;
              // The final tile index is kept so tile_idx_o reads K-1
              // through DRAIN and FLUSH.
              if (w_tile_last) begin
                r_state <= ST_DRAIN;
              end else begin
                r_tile <= r_tile + KT_W'(1);
              end
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready_i) begin
            if (w_row_last) begin
              r_row   <= '0;
              r_state <= ST_FLUSH;
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          // Wait for the last drain beat to reach column PE_SIZE-1.
          if (w_flush_last) begin
            r_row   <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Column-0 control decode (Mealy on state and the beat strobes).
  // Tile 0 accumulates onto zero without popping; later tiles pop the head
  // and feed it back in the same cycle the new sum is pushed.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_c0 = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    case (r_state)
      ST_ACCUM: begin
        if (psum_valid_i) begin
          w_c0 = mk_ctrl(1'b1, (r_tile != '0), (r_tile != '0), 1'b0);
        end
      end
      ST_DRAIN: begin
        if (out_ready_i) begin
          w_c0 = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1);
        end
      end
      default: w_c0 = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endcase
  end

  acc_skew_chain #(
    .STAGES (PE_SIZE - 1)
  ) u_skew (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ctrl  (w_c0),
    .o_taps  (w_taps)
  );

  // Column 0 is the live decode; column j is chain tap j-1.
  assign w_col = {w_taps, w_c0};

  for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
    assign wren_o[j]      = w_col[j].wren;
    assign rden_o[j]      = w_col[j].rden;
    assign sel_o[j]       = w_col[j].sel;
    assign out_valid_o[j] = w_col[j].valid;
  end

  assign tile_idx_o  = r_tile;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign dbg_state_o = acc_state_e'(r_state);

endmodule

// File: tb/tb_acc_sched.sv
// -----------------------------------------------------------------------------
// tb_acc_sched
//   Directed bench for acc_sched with PE_SIZE=4. A behavioural model of the
//   per-column accumulator FIFOs is driven by the DUT's control lines; the
//   drained sums are checked against per-column expected queues filled by
//   the driver when each job is issued.
// -----------------------------------------------------------------------------
module tb_acc_sched;
  import acc_sched_pkg::*;

  localparam int PE   = 4;
  localparam int KT_W = 8;
  localparam int DW   = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic            start_i, psum_valid_i, out_ready_i;
  logic [KT_W-1:0] num_ktile_i;
  logic [PE-1:0]   wren_o, rden_o, sel_o, out_valid_o;
  logic [KT_W-1:0] tile_idx_o;
  logic            busy_o, done_o;
  acc_state_e      dbg_state_o;

  acc_sched #(.PE_SIZE(PE), .FIFO_DEPTH(PE), .KT_W(KT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .num_ktile_i  (num_ktile_i),
    .psum_valid_i (psum_valid_i),
    .out_ready_i  (out_ready_i),
    .wren_o       (wren_o),
    .rden_o       (rden_o),
    .sel_o        (sel_o),
    .out_valid_o  (out_valid_o),
    .tile_idx_o   (tile_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------------------------------------------------------- state
  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] psum_data;
  logic [DW-1:0] hist [PE];          // hist[j] = column-0 data j cycles ago
  logic [DW-1:0] fifo_q [PE][$];     // accumulator FIFO model per column
  logic [DW-1:0] exp_q [PE][$];      // expected drained sums per column
  logic [DW-1:0] head_v, exp_v;

  int wr_cnt [PE];
  int rd_cnt [PE];
  int selwr_cnt [PE];
  int max_occ [PE];
  int first_wr [PE];
  int last_wr [PE];
  int first_vd [PE];
  int last_vd [PE];
  int done_cnt, done_cyc, idle_ctrl_cnt;
  int vals [64];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  // Runs mid-cycle, when the DUT's controls for this cycle are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = PE - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = psum_valid_i ? psum_data : '0;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy_o && ((wren_o | rden_o | sel_o | out_valid_o) != '0)) idle_ctrl_cnt++;
      for (int j = 0; j < PE; j++) begin
        head_v = (fifo_q[j].size() > 0) ? fifo_q[j][0] : '0;
        if (out_valid_o[j]) begin
          if (first_vd[j] < 0) first_vd[j] = cyc;
          last_vd[j] = cyc;
          if (exp_q[j].size() == 0) begin
            chk($sformatf("unexpected_out_col%0d", j), 1, 0);
          end else begin
            exp_v = exp_q[j].pop_front();
            chk($sformatf("drain_sum_col%0d", j), int'(head_v), int'(exp_v));
          end
        end
        if (rden_o[j]) begin
          rd_cnt[j]++;
          chk($sformatf("pop_nonempty_col%0d", j), int'(fifo_q[j].size() > 0), 1);
          if (fifo_q[j].size() > 0) void'(fifo_q[j].pop_front());
        end
        if (wren_o[j]) begin
          wr_cnt[j]++;
          if (sel_o[j]) selwr_cnt[j]++;
          if (first_wr[j] < 0) first_wr[j] = cyc;
          last_wr[j] = cyc;
          fifo_q[j].push_back((sel_o[j] ? head_v : DW'(0)) + hist[j]);
          if (fifo_q[j].size() > max_occ[j]) max_occ[j] = fifo_q[j].size();
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic clear_stats();
    for (int j = 0; j < PE; j++) begin
      wr_cnt[j] = 0; rd_cnt[j] = 0; selwr_cnt[j] = 0; max_occ[j] = 0;
      first_wr[j] = -1; last_wr[j] = -1; first_vd[j] = -1; last_vd[j] = -1;
    end
    done_cnt = 0; done_cyc = -1; idle_ctrl_cnt = 0;
  endtask

  // One complete job. vals[] holds the column-0 data for beat b = tile*4+row.
  task automatic run_job(input int k_in, input int gap_beat, input int gap_len,
                         input int stall_beat, input int stall_len,
                         input bit start_in_drain, input int exp_lat,
                         input bit timing);
    int kreq, t0, beats, gap, dbeats, st, sum;
    kreq = (k_in == 0) ? 1 : k_in;
    clear_stats();
    for (int r = 0; r < PE; r++) begin
      sum = 0;
      for (int t = 0; t < kreq; t++) sum += vals[t*PE + r];
      for (int j = 0; j < PE; j++) exp_q[j].push_back(DW'(sum));
    end
    chk("busy_before_start", int'(busy_o), 0);
    start_i = 1'b1;
    num_ktile_i = KT_W'(k_in);
    t0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_cycle1", int'(busy_o), 1);
    beats = 0; gap = 0;
    while (beats < kreq * PE) begin
      if (beats == gap_beat && gap < gap_len) begin
        psum_valid_i = 1'b0;
        gap++;
      end else begin
        psum_valid_i = 1'b1;
        psum_data = DW'(vals[beats]);
        chk("tile_idx_accum", int'(tile_idx_o), beats / PE);
        beats++;
      end
      @(posedge clk); #1;
    end
    psum_valid_i = 1'b0;
    chk("state_drain", int'(dbg_state_o), 2);
    chk("tile_idx_drain", int'(tile_idx_o), kreq - 1);
    dbeats = 0; st = 0;
    while (dbeats < PE) begin
      start_i = (start_in_drain && dbeats == 1 && st == 0);
      num_ktile_i = start_i ? KT_W'(7) : num_ktile_i;
      if (dbeats == stall_beat && st < stall_len) begin
        out_ready_i = 1'b0;
        st++;
      end else begin
        out_ready_i = 1'b1;
        dbeats++;
      end
      @(posedge clk); #1;
    end
    out_ready_i = 1'b0;
    start_i = 1'b0;
    for (int w = 0; w < 60 && done_cnt == 0; w++) @(negedge clk);
    chk("done_latency", done_cyc - t0, exp_lat);
    repeat (2) @(negedge clk);
    chk("done_pulse_count", done_cnt, 1);
    chk("busy_after_done", int'(busy_o), 0);
    chk("idle_spurious_ctrl", idle_ctrl_cnt, 0);
    for (int j = 0; j < PE; j++) begin
      chk($sformatf("wr_cnt_col%0d", j), wr_cnt[j], kreq * PE);
      chk($sformatf("rd_cnt_col%0d", j), rd_cnt[j], kreq * PE);
      chk($sformatf("sel_on_write_col%0d", j), selwr_cnt[j], (kreq - 1) * PE);
      chk($sformatf("max_occ_col%0d", j), int'(max_occ[j] <= PE), 1);
      chk($sformatf("fifo_empty_col%0d", j), fifo_q[j].size(), 0);
      chk($sformatf("exp_q_empty_col%0d", j), exp_q[j].size(), 0);
    end
    if (timing) begin
      chk("col0_first_wr", first_wr[0] - t0, 1);
      chk("col0_last_wr",  last_wr[0]  - t0, 4);
      chk("col0_first_vd", first_vd[0] - t0, 5);
      chk("col0_last_vd",  last_vd[0]  - t0, 8);
      chk("col3_first_wr", first_wr[3] - t0, 4);
      chk("col3_last_wr",  last_wr[3]  - t0, 7);
      chk("col3_first_vd", first_vd[3] - t0, 8);
      chk("col3_last_vd",  last_vd[3]  - t0, 11);
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    rst_n = 1'b0;
    start_i = 1'b0; psum_valid_i = 1'b0; out_ready_i = 1'b0;
    num_ktile_i = '0; psum_data = '0;
    for (int j = 0; j < PE; j++) hist[j] = '0;
    clear_stats();
    repeat (3) @(posedge clk); #1;
    chk("rst_wren", int'(wren_o), 0);
    chk("rst_rden", int'(rden_o), 0);
    chk("rst_sel", int'(sel_o), 0);
    chk("rst_valid", int'(out_valid_o), 0);
    chk("rst_tile_idx", int'(tile_idx_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_state", int'(dbg_state_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // K=1, no stalls: rows 1,4,7,10
    for (int b = 0; b < 64; b++) vals[b] = 3 * b + 1;
    run_job(1, -1, 0, -1, 0, 1'b0, 12, 1'b1);

    // K=3, tiles of 5,7,9 -> 21 on every column
    for (int b = 0; b < 64; b++) vals[b] = (b < 4) ? 5 : ((b < 8) ? 7 : 9);
    run_job(3, -1, 0, -1, 0, 1'b0, 20, 1'b0);

    // K=2, 2-cycle psum gap at beat 2 and 3-cycle ready stall at drain beat 1
    for (int b = 0; b < 64; b++) vals[b] = 3 * b + 1;
    run_job(2, 2, 2, 1, 3, 1'b0, 21, 1'b0);

    // num_ktile_i = 0 behaves as K=1
    for (int b = 0; b < 64; b++) vals[b] = 2 * b + 11;
    run_job(0, -1, 0, -1, 0, 1'b0, 12, 1'b1);

    // start_i pulsed in DRAIN is ignored; back-to-back fresh job afterwards
    for (int b = 0; b < 64; b++) vals[b] = b + 100;
    run_job(2, -1, 0, -1, 0, 1'b1, 16, 1'b0);
    for (int b = 0; b < 64; b++) vals[b] = 40 - b;
    run_job(1, -1, 0, -1, 0, 1'b0, 12, 1'b0);

    // Reset during ACCUM tile 1
    clear_stats();
    for (int b = 0; b < 64; b++) vals[b] = 9;
    start_i = 1'b1;
    num_ktile_i = KT_W'(3);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int b = 0; b < 6; b++) begin
      psum_valid_i = 1'b1;
      psum_data = DW'(vals[b]);
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", int'(busy_o), 1);
    chk("pre_reset_tile", int'(tile_idx_o), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wren", int'(wren_o), 0);
    chk("mid_rst_rden", int'(rden_o), 0);
    chk("mid_rst_sel", int'(sel_o), 0);
    chk("mid_rst_valid", int'(out_valid_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_tile", int'(tile_idx_o), 0);
    psum_valid_i = 1'b0;
    for (int j = 0; j < PE; j++) begin
      fifo_q[j].delete();
      exp_q[j].delete();
    end
    repeat (2) @(posedge clk); #1;
    chk("mid_rst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 64; b++) vals[b] = 5 * b + 2;
    run_job(2, -1, 0, -1, 0, 1'b0, 16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
